// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the round sequencer.
package aes_pkg;

  localparam int unsigned NB      = 4;
  localparam int unsigned BLOCK_W = 128;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  // Round constants, Rcon[i] in the MSB byte of each word.
  localparam logic [31:0] RCON [10] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, zero maps to zero) plus affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One step of the AES-128 key schedule: round key i -> round key i+1.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [31:0] rcon);
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ rcon;
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] rkey_i,
  input  logic               final_i,
  output logic [BLOCK_W-1:0] state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte i sits at bits [127-8i -: 8]; byte index is row + 4*column.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    state_o = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_i[BLOCK_W-1-8*i -: 8]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int i = 0; i < 16; i++) begin
      state_o[BLOCK_W-1-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ rkey_i[BLOCK_W-1-8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [Nk*32-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
  output logic [3:0]         round
);

  state_e             st_q, st_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [BLOCK_W-1:0] rkey_q, rkey_d;
  logic [3:0]         round_q, round_d;
  logic [3:0]         rcon_idx;
  logic [BLOCK_W-1:0] next_key;
  logic [BLOCK_W-1:0] round_out;

  // Round counter is 0 only in idle, where the key step result is unused.
  assign rcon_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
  assign next_key = key_step(rkey_q, RCON[rcon_idx]);

  aes_round u_round (
    .state_i (state_q),
    .rkey_i  (next_key),
    .final_i (st_q == StFinal),
    .state_o (round_out)
  );

  // State register, round key, counter and FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      state_q <= '0;
      rkey_q  <= '0;
      round_q <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      round_q <= round_d;
    end
  end

  // Next-state: load on accept, iterate rounds, hold result until consumed.
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    round_d = round_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          state_d = in_data ^ in_key;
          rkey_d  = in_key;
          round_d = 4'd1;
          st_d    = StRound;
        end
      end
      StRound: begin
        state_d = round_out;
        rkey_d  = next_key;
        round_d = round_q + 4'd1;
        if (round_q == 4'(Nr - 1)) st_d = StFinal;
      end
      StFinal: begin
        state_d = round_out;
        rkey_d  = next_key;
        st_d    = StDone;
      end
      StDone: begin
        if (out_ready) begin
          round_d = '0;
          st_d    = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  assign in_ready  = (st_q == StIdle);
  assign busy      = (st_q == StRound) || (st_q == StFinal);
  assign out_valid = (st_q == StDone);
  assign out_data  = state_q;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer using FIPS-197 vectors.
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_sequencer #(.Nk(4), .Nr(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round     (round)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Bounded wait for out_valid; returns number of cycles waited.
  task automatic wait_out(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      step();
      cycles++;
    end
  endtask

  // Offer a pair for exactly one edge; caller guarantees the DUT is idle.
  task automatic accept(input logic [127:0] p, input logic [127:0] k);
    in_data  = p;
    in_key   = k;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", out_valid, busy);
    else pass_cnt++;
    total_cnt++;
    if (round !== 4'd0) $display("FAIL reset_round: got %0d want 0", round);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 128'h0) $display("FAIL reset_data: got %h want 0", out_data);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_fips();
    int cyc;
    out_ready = 1'b1;
    accept(P1, K1);
    total_cnt++;
    if (busy !== 1'b1 || round !== 4'd1 || in_ready !== 1'b0)
      $display("FAIL fips_start: busy=%b round=%0d in_ready=%b want 1 1 0", busy, round, in_ready);
    else pass_cnt++;
    wait_out(cyc);
    total_cnt++;
    if (cyc != 10) $display("FAIL fips_latency: got %0d want 10", cyc);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== C1 || round !== 4'd10) $display("FAIL fips_data: got %h round %0d want %h round 10", out_data, round, C1);
    else pass_cnt++;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || round !== 4'd0)
      $display("FAIL fips_idle: in_ready=%b out_valid=%b round=%0d want 1 0 0", in_ready, out_valid, round);
    else pass_cnt++;
  endtask

  task automatic test_vec2();
    int cyc;
    out_ready = 1'b1;
    accept(P2, K2);
    wait_out(cyc);
    total_cnt++;
    if (cyc != 10 || out_data !== C2) $display("FAIL vec2: got %h after %0d want %h after 10", out_data, cyc, C2);
    else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    accept(P1, K1);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (out_data !== C1 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || round !== 4'd10)
        $display("FAIL hold_%0d: data=%h ov=%b ir=%b busy=%b round=%0d want %h 1 0 0 10",
                 i, out_data, out_valid, in_ready, busy, round, C1);
      else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL hold_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_input_change();
    int cyc;
    out_ready = 1'b0;
    accept(P1, K1);
    step();
    step();
    step();
    in_data  = P2;
    in_key   = K2;
    in_valid = 1'b1;
    wait_out(cyc);
    total_cnt++;
    if (cyc != 7 || out_data !== C1) $display("FAIL change_result: got %h after %0d want %h after 7", out_data, cyc, C1);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL change_idle: in_ready=%b busy=%b want 1 0", in_ready, busy);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || round !== 4'd1) $display("FAIL pending_accept: busy=%b round=%0d want 1 1", busy, round);
    else pass_cnt++;
    wait_out(cyc);
    total_cnt++;
    if (cyc != 10 || out_data !== C2) $display("FAIL pending_result: got %h after %0d want %h after 10", out_data, cyc, C2);
    else pass_cnt++;
    step();
  endtask

  task automatic test_midreset();
    int cyc;
    int seen;
    out_ready = 1'b1;
    accept(P1, K1);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || round !== 4'd0 || out_data !== 128'h0)
      $display("FAIL midreset_async: ov=%b busy=%b round=%0d data=%h want 0 0 0 0", out_valid, busy, round, out_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL midreset_discard: got %0d out_valid cycles want 0", seen);
    else pass_cnt++;
    accept(P2, K2);
    wait_out(cyc);
    total_cnt++;
    if (cyc != 10 || out_data !== C2) $display("FAIL midreset_new: got %h after %0d want %h after 10", out_data, cyc, C2);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    int t0;
    int t1;
    int bad;
    int exp_r;
    logic [127:0] d0;
    logic [127:0] d1;
    n = 0; t0 = -1; t1 = -1; bad = 0; d0 = '0; d1 = '0;
    out_ready = 1'b1;
    in_data   = P1;
    in_key    = K1;
    in_valid  = 1'b1;
    step();
    in_data = P2;
    in_key  = K2;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      step();
      if (cyc == 12) in_valid = 1'b0;
      if (cyc <= 12) begin
        exp_r = (cyc <= 8) ? cyc + 1 : (cyc <= 10) ? 10 : (cyc == 11) ? 0 : 1;
        if (round !== 4'(exp_r)) begin
          if (bad == 0) $display("FAIL b2b_trace: cycle %0d round %0d want %0d", cyc, round, exp_r);
          bad++;
        end
      end
      if (cyc == 11) begin
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_gap: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else pass_cnt++;
      end
      if (out_valid === 1'b1) begin
        if (n == 0) begin t0 = cyc; d0 = out_data; end
        else if (n == 1) begin t1 = cyc; d1 = out_data; end
        n++;
      end
    end
    total_cnt++;
    if (bad != 0) $display("FAIL b2b_trace_total: %0d bad cycles want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (n != 2) $display("FAIL b2b_count: got %0d outputs want 2", n);
    else pass_cnt++;
    total_cnt++;
    if (t0 != 10 || d0 !== C1) $display("FAIL b2b_first: got %h at %0d want %h at 10", d0, t0, C1);
    else pass_cnt++;
    total_cnt++;
    if (t1 - t0 != 12 || d1 !== C2) $display("FAIL b2b_second: got %h spacing %0d want %h spacing 12", d1, t1 - t0, C2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_vec2();
    test_backpressure();
    test_input_change();
    test_midreset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL declare parameter Nk, default 4, meaning key length in 32-bit words; only 4 is supported.
REQ-002 SHALL declare parameter Nr, default 10, meaning number of rounds; only 10 is supported.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning a block/key pair is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the sequencer can accept a pair.
REQ-007 SHALL have port in_data, input, 128, meaning plaintext block, byte 0 at bits [127:120].
REQ-008 SHALL have port in_key, input, Nk*32, meaning cipher key, word 0 at the MSBs.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data holds a finished ciphertext.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-011 SHALL have port out_data, output, 128, meaning ciphertext block.
REQ-012 SHALL have port busy, output, 1, meaning the state is ROUND or FINAL.
REQ-013 SHALL have port round, output, 4, meaning the current round counter value.

Function
REQ-014 SHALL implement FSM states IDLE, ROUND, FINAL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a pair when in_valid and in_ready are both 1 on an edge (edge T): state <= in_data XOR in_key, rkey <= in_key, round <= 1, FSM -> ROUND.
REQ-016 In ROUND, each edge SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey with the next round key; rkey <= next round key; round increments.
REQ-017 SHALL derive the next round key combinationally from rkey and Rcon[round-1], using the standard AES-128 expansion (RotWord, SubWord, XOR chain).
REQ-018 ROUND -> FINAL SHALL occur on the edge where round goes from 9 to 10, i.e. edge T+9.
REQ-019 In FINAL, the edge SHALL apply SubBytes, ShiftRows and AddRoundKey with no MixColumns, then FSM -> DONE at edge T+10.
REQ-020 out_valid SHALL be 1 exactly in DONE; latency from the accept edge to first out_valid SHALL be 10 cycles.
REQ-021 out_data SHALL equal the state register and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 DONE -> IDLE SHALL occur on an edge with out_ready=1; in_ready rises the following cycle, so there is no same-cycle accept/emit.
REQ-023 in_data and in_key SHALL be sampled only at the accept edge; later changes SHALL have no effect on the result.
REQ-024 in_valid while not in IDLE SHALL be ignored; the pair is not lost but waits, because the handshake has not completed.
REQ-025 The round counter SHALL never exceed 10 and SHALL be 0 in IDLE and 10 in DONE.
REQ-026 The minimum throughput SHALL be one block per 12 cycles with out_ready held at 1.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM IDLE, state 0, rkey 0, round 0, out_valid 0, busy 0, in_ready 1 once released.
REQ-028 Reset mid-operation SHALL discard the in-flight block; no out_valid follows for it.
REQ-029 Deassertion of reset SHALL be synchronised by the existing reset-sync block at the top level; this module uses rst_n directly.

Structure
REQ-030 A shared package aes_pkg SHALL hold the Rcon table (10 x 32 bit), the FSM state typedef, and the constants NB=4 and BLOCK_W=128.
REQ-031 One sub-module aes_round SHALL hold the combinational round (Sbox, ShiftRows, MixColumns with bypass input final, AddRoundKey), reusing the existing leaf blocks.
REQ-032 Key expansion SHALL reuse the existing KeyExpansion single-step block; this module holds only registers, the FSM and the counter.

Verification
REQ-033 Reset, accept key 2b7e151628aed2a6abf7158809cf4f3c and pt 3243f6a8885a308d313198a2e0370734 -> out_valid at T+10, out_data 3925841d02dc09fbdc118597196a0b32.
REQ-034 Accept key 000102030405060708090a0b0c0d0e0f and pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready 0, busy 0; then out_ready=1 -> IDLE next edge.
REQ-036 Change in_data and in_key at T+3, and assert in_valid while busy -> result unchanged from REQ-033 and no second accept until IDLE.
REQ-037 Assert rst_n=0 at T+5 -> all outputs reset values immediately; a new pair after release -> correct result with 10-cycle latency.
REQ-038 Back-to-back: two pairs with in_valid and out_ready held at 1 -> results in order, 12-cycle spacing, round trace 0,1..10,0.
